// File: rtl/axis_512to256_conv.sv
`default_nettype none
// ============================================================================
// Module      : axis_512to256_conv
// Description : AXI-Stream 512b -> 256b ingress width converter. Each accepted
//               input beat is emitted as a low 256b beat, followed by a high
//               256b beat only when the upper 32 byte lanes carry data.
//               Optional statistics counters are built when the macro
//               AXIS_WIDTH_CONV_STATS_EN is defined; otherwise the stat
//               ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_512to256_conv #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       stat_pkt_cnt,
    output logic [31:0]                       stat_beat_cnt
);

    localparam int C_S_KEEP_WIDTH = C_S_AXIS_DATA_WIDTH / 8;
    localparam int C_M_KEEP_WIDTH = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } state_t;

    state_t                            r_state;
    // Only the upper half of an accepted beat needs holding: the lower half
    // is loaded straight into the output registers at accept time.
    logic [C_M_AXIS_DATA_WIDTH-1:0]    r_hi_data;
    logic [C_M_KEEP_WIDTH-1:0]         r_hi_keep;
    logic                              r_hi_last;

    logic                              w_hi_pending;
    logic                              w_in_hi_pending;
    logic                              w_accept;

    assign w_hi_pending    = |r_hi_keep;
    assign w_in_hi_pending = |s_axis_tkeep[C_S_KEEP_WIDTH-1:C_M_KEEP_WIDTH];

    // Ready depends only on state and downstream ready, never on s_axis_tvalid.
    assign s_axis_tready = (r_state == ST_EMPTY)
                         | ((r_state == ST_HI) & m_axis_tready)
                         | ((r_state == ST_LO) & m_axis_tready & ~w_hi_pending);

    assign w_accept = s_axis_tvalid & s_axis_tready;

    // Converter FSM with registered output beat and upper-half holding register.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state       <= ST_EMPTY;
            r_hi_data     <= '0;
            r_hi_keep     <= '0;
            r_hi_last     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY, ST_LO, ST_HI: begin
                    if (w_accept) begin
                        // Accept is only possible once the current beat (if any)
                        // is leaving, so a new low half can be presented directly.
                        r_state       <= ST_LO;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata[C_M_AXIS_DATA_WIDTH-1:0];
                        m_axis_tkeep  <= s_axis_tkeep[C_M_KEEP_WIDTH-1:0];
                        m_axis_tuser  <= s_axis_tuser;
                        m_axis_tlast  <= s_axis_tlast & ~w_in_hi_pending;
                        r_hi_data     <= s_axis_tdata[C_S_AXIS_DATA_WIDTH-1:C_M_AXIS_DATA_WIDTH];
                        r_hi_keep     <= s_axis_tkeep[C_S_KEEP_WIDTH-1:C_M_KEEP_WIDTH];
                        r_hi_last     <= s_axis_tlast;
                    end else if ((r_state == ST_LO) && m_axis_tready && w_hi_pending) begin
                        // Low half consumed; present the high half, tuser unchanged.
                        r_state      <= ST_HI;
                        m_axis_tdata <= r_hi_data;
                        m_axis_tkeep <= r_hi_keep;
                        m_axis_tlast <= r_hi_last;
                    end else if ((r_state != ST_EMPTY) && m_axis_tready) begin
                        r_state       <= ST_EMPTY;
                        m_axis_tvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_EMPTY;
                    m_axis_tvalid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS_WIDTH_CONV_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_beat_cnt;
    logic        w_out_fire;

    assign w_out_fire = m_axis_tvalid & m_axis_tready;

    // Free-running wrap-around counters of output beats and packets.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_pkt_cnt  <= '0;
            r_beat_cnt <= '0;
        end else if (w_out_fire) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
            if (m_axis_tlast) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt  = r_pkt_cnt;
    assign stat_beat_cnt = r_beat_cnt;
`else
    assign stat_pkt_cnt  = 32'd0;
    assign stat_beat_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_512to256_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_512to256_conv
// Description : Directed self-checking bench for axis_512to256_conv.
//               Expected statistics depend on AXIS_WIDTH_CONV_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_512to256_conv;

    logic         clk;
    logic         aresetn;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  stat_pkt_cnt;
    logic [31:0]  stat_beat_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // input beat queue
    logic [511:0] q_data[$];
    logic [63:0]  q_keep[$];
    logic [127:0] q_user[$];
    logic         q_last[$];
    // m_axis_tready pattern (cyclic; empty means always ready)
    bit           rdy_pat[$];
    // per-cycle log
    bit           lg_mv[$];
    bit           lg_mr[$];
    bit           lg_sr[$];
    logic [255:0] lg_data[$];
    logic [31:0]  lg_keep[$];
    logic [127:0] lg_user[$];
    logic         lg_last[$];
    // captured output transfers
    logic [255:0] out_data[$];
    logic [31:0]  out_keep[$];
    logic [127:0] out_user[$];
    logic         out_last[$];

    axis_512to256_conv dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_beat_cnt (stat_beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // byte i = base + i (mod 256)
    function automatic logic [511:0] seq512(input int base);
        logic [511:0] v;
        for (int i = 0; i < 64; i++) v[i*8 +: 8] = 8'(base + i);
        return v;
    endfunction

    function automatic logic [255:0] seq256(input int base);
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'(base + i);
        return v;
    endfunction

    task automatic push_in(input logic [511:0] d, input logic [63:0] k,
                           input logic [127:0] u, input logic l);
        q_data.push_back(d);
        q_keep.push_back(k);
        q_user.push_back(u);
        q_last.push_back(l);
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    // Drive queued inputs, log every cycle, collect output transfers.
    task automatic run_traffic(input string name, input int n_out, input int budget);
        int idx = 0;
        int cyc = 0;
        lg_mv.delete(); lg_mr.delete(); lg_sr.delete(); lg_data.delete();
        lg_keep.delete(); lg_user.delete(); lg_last.delete();
        out_data.delete(); out_keep.delete(); out_user.delete(); out_last.delete();
        while (out_data.size() < n_out && cyc < budget) begin
            @(negedge clk);
            m_axis_tready = (rdy_pat.size() == 0) ? 1'b1 : rdy_pat[cyc % rdy_pat.size()];
            if (idx < q_data.size()) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = q_data[idx];
                s_axis_tkeep  = q_keep[idx];
                s_axis_tuser  = q_user[idx];
                s_axis_tlast  = q_last[idx];
            end else begin
                s_axis_tvalid = 1'b0;
            end
            #1;
            lg_mv.push_back(m_axis_tvalid);
            lg_mr.push_back(m_axis_tready);
            lg_sr.push_back(s_axis_tready);
            lg_data.push_back(m_axis_tdata);
            lg_keep.push_back(m_axis_tkeep);
            lg_user.push_back(m_axis_tuser);
            lg_last.push_back(m_axis_tlast);
            if (s_axis_tvalid && s_axis_tready) idx++;
            if (m_axis_tvalid && m_axis_tready) begin
                out_data.push_back(m_axis_tdata);
                out_keep.push_back(m_axis_tkeep);
                out_user.push_back(m_axis_tuser);
                out_last.push_back(m_axis_tlast);
            end
            cyc++;
        end
        if (out_data.size() < n_out) begin
            tests_run++; tests_failed++;
            $display("FAIL %s timeout: got %0d beats, need %0d", name, out_data.size(), n_out);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        q_data.delete(); q_keep.delete(); q_user.delete(); q_last.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid got %b exp 0", m_axis_tvalid); end
        tests_run++;
        if (m_axis_tdata !== 256'd0 || m_axis_tkeep !== 32'd0 || m_axis_tuser !== 128'd0 || m_axis_tlast !== 1'b0) begin
            tests_failed++; $display("FAIL reset_outputs got keep %h last %b exp zeros", m_axis_tkeep, m_axis_tlast);
        end
        tests_run++;
        if (s_axis_tready !== 1'b1) begin tests_failed++; $display("FAIL reset_tready got %b exp 1", s_axis_tready); end
        tests_run++;
        if (stat_pkt_cnt !== 32'd0 || stat_beat_cnt !== 32'd0) begin
            tests_failed++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_pkt_cnt, stat_beat_cnt);
        end
    endtask

    task automatic test_single_full();
        push_in(seq512(8'h00), {64{1'b1}}, 128'hA5A5_0001, 1'b1);
        run_traffic("single_full", 2, 20);
        tests_run++;
        if (out_data.size() !== 2) begin tests_failed++; $display("FAIL single_count got %0d exp 2", out_data.size()); end
        else begin
            tests_run++;
            if (out_data[0] !== seq256(8'h00) || out_keep[0] !== 32'hFFFF_FFFF || out_last[0] !== 1'b0) begin
                tests_failed++; $display("FAIL single_beat1 got %h/%h/%b exp %h/ffffffff/0", out_data[0], out_keep[0], out_last[0], seq256(8'h00));
            end
            tests_run++;
            if (out_data[1] !== seq256(8'h20) || out_keep[1] !== 32'hFFFF_FFFF || out_last[1] !== 1'b1) begin
                tests_failed++; $display("FAIL single_beat2 got %h/%h/%b exp %h/ffffffff/1", out_data[1], out_keep[1], out_last[1], seq256(8'h20));
            end
            tests_run++;
            if (out_user[0] !== 128'hA5A5_0001 || out_user[1] !== 128'hA5A5_0001) begin
                tests_failed++; $display("FAIL single_tuser got %h/%h exp a5a50001", out_user[0], out_user[1]);
            end
            tests_run++;
            if (lg_mv.size() !== 3 || lg_mv[0] !== 1'b0 || lg_mv[1] !== 1'b1 || lg_mv[2] !== 1'b1) begin
                tests_failed++; $display("FAIL single_latency got %0d log cycles exp valid at cycles 1,2 of 3", lg_mv.size());
            end
        end
    endtask

    task automatic test_short_tail();
        push_in(seq512(8'h40), {64{1'b1}}, 128'h2, 1'b0);
        push_in(seq512(8'h80), 64'h0000_0000_0000_FFFF, 128'h2, 1'b1);
        run_traffic("short_tail", 3, 20);
        tests_run++;
        if (out_data.size() !== 3) begin tests_failed++; $display("FAIL tail_count got %0d exp 3", out_data.size()); end
        else begin
            tests_run++;
            if (out_data[1] !== seq256(8'h60) || out_last[1] !== 1'b0) begin
                tests_failed++; $display("FAIL tail_mid got %h/%b exp %h/0", out_data[1], out_last[1], seq256(8'h60));
            end
            tests_run++;
            if (out_data[2] !== seq256(8'h80) || out_keep[2] !== 32'h0000_FFFF || out_last[2] !== 1'b1) begin
                tests_failed++; $display("FAIL tail_last got %h/%h/%b exp %h/0000ffff/1", out_data[2], out_keep[2], out_last[2], seq256(8'h80));
            end
            tests_run++;
            if (lg_sr[lg_sr.size()-1] !== 1'b1) begin
                tests_failed++; $display("FAIL tail_tready got %b exp 1", lg_sr[lg_sr.size()-1]);
            end
        end
    endtask

    task automatic test_zero_keep();
        push_in(seq512(8'h33), 64'd0, 128'h77, 1'b1);
        run_traffic("zero_keep", 1, 20);
        tests_run++;
        if (out_data.size() !== 1) begin tests_failed++; $display("FAIL zero_count got %0d exp 1", out_data.size()); end
        else begin
            tests_run++;
            if (out_keep[0] !== 32'd0 || out_last[0] !== 1'b1 || out_data[0] !== seq256(8'h33)) begin
                tests_failed++; $display("FAIL zero_beat got %h/%b exp 00000000/1", out_keep[0], out_last[0]);
            end
        end
        // no phantom high beat afterwards
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL zero_extra got tvalid %b exp 0", m_axis_tvalid); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        bit exp_sr;
        push_in(seq512(8'h00), {64{1'b1}}, 128'h11, 1'b0);
        push_in(seq512(8'h40), {64{1'b1}}, 128'h11, 1'b0);
        push_in(seq512(8'h80), {64{1'b1}}, 128'h11, 1'b1);
        rdy_pat = '{1, 0, 0, 1, 0, 1};
        run_traffic("backpressure", 6, 60);
        rdy_pat.delete();
        tests_run++;
        if (out_data.size() !== 6) begin tests_failed++; $display("FAIL bp_count got %0d exp 6", out_data.size()); end
        else begin
            for (int j = 0; j < 6; j++) begin
                tests_run++;
                if (out_data[j] !== seq256(j * 32) || out_last[j] !== (j == 5)) begin
                    tests_failed++; $display("FAIL bp_beat%0d got %h/%b exp %h/%b", j, out_data[j], out_last[j], seq256(j * 32), (j == 5));
                end
            end
        end
        for (int i = 0; i < lg_mv.size(); i++) begin
            // even output index = low half with high half pending
            exp_sr = !lg_mv[i] ? 1'b1 : ((k % 2 == 0) ? 1'b0 : lg_mr[i]);
            tests_run++;
            if (lg_sr[i] !== exp_sr) begin
                tests_failed++; $display("FAIL bp_tready cycle %0d got %b exp %b", i, lg_sr[i], exp_sr);
            end
            if (i > 0 && lg_mv[i-1] && !lg_mr[i-1]) begin
                tests_run++;
                if (lg_mv[i] !== 1'b1 || lg_data[i] !== lg_data[i-1] || lg_keep[i] !== lg_keep[i-1] ||
                    lg_last[i] !== lg_last[i-1] || lg_user[i] !== lg_user[i-1]) begin
                    tests_failed++; $display("FAIL bp_stall cycle %0d got valid %b data %h exp stable %h", i, lg_mv[i], lg_data[i], lg_data[i-1]);
                end
            end
            if (lg_mv[i] && lg_mr[i]) k++;
        end
    endtask

    task automatic test_streaming();
        for (int b = 0; b < 8; b++) push_in(seq512(b * 64), {64{1'b1}}, 128'(b), (b % 4 == 3));
        run_traffic("streaming", 16, 60);
        tests_run++;
        if (out_data.size() !== 16 || lg_mv.size() !== 17) begin
            tests_failed++; $display("FAIL stream_count got %0d beats in %0d cycles exp 16 in 17", out_data.size(), lg_mv.size());
        end else begin
            for (int i = 1; i < 17; i++) begin
                tests_run++;
                if (lg_mv[i] !== 1'b1) begin tests_failed++; $display("FAIL stream_bubble cycle %0d got 0 exp 1", i); end
            end
            for (int i = 0; i < 17; i++) begin
                tests_run++;
                if (lg_sr[i] !== (i % 2 == 0)) begin tests_failed++; $display("FAIL stream_tready cycle %0d got %b exp %b", i, lg_sr[i], (i % 2 == 0)); end
            end
            for (int j = 0; j < 16; j++) begin
                tests_run++;
                if (out_data[j] !== seq256(j * 32) || out_last[j] !== (j % 8 == 7) || out_user[j] !== 128'(j / 2)) begin
                    tests_failed++; $display("FAIL stream_beat%0d got %h/%b/%h exp %h/%b/%h", j, out_data[j], out_last[j], out_user[j], seq256(j * 32), (j % 8 == 7), 128'(j / 2));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = seq512(8'h50);
        s_axis_tkeep  = {64{1'b1}};
        s_axis_tuser  = 128'h99;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        m_axis_tready = 1'b0;
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== seq256(8'h70)) begin
            tests_failed++; $display("FAIL rstmid_hi got %b/%h exp 1/%h", m_axis_tvalid, m_axis_tdata, seq256(8'h70));
        end
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            tests_failed++; $display("FAIL rstmid_state got tvalid %b tready %b exp 0/1", m_axis_tvalid, s_axis_tready);
        end
        tests_run++;
        if (stat_pkt_cnt !== 32'd0 || stat_beat_cnt !== 32'd0) begin
            tests_failed++; $display("FAIL rstmid_stats got %0d/%0d exp 0/0", stat_pkt_cnt, stat_beat_cnt);
        end
        push_in(seq512(8'h08), {64{1'b1}}, 128'h5, 1'b1);
        run_traffic("reset_mid", 2, 20);
        tests_run++;
        if (out_data.size() !== 2) begin tests_failed++; $display("FAIL rstmid_count got %0d exp 2", out_data.size()); end
        else begin
            tests_run++;
            if (out_data[0] !== seq256(8'h08) || out_data[1] !== seq256(8'h28) || out_last[0] !== 1'b0 || out_last[1] !== 1'b1) begin
                tests_failed++; $display("FAIL rstmid_pkt got %h/%h exp %h/%h", out_data[0], out_data[1], seq256(8'h08), seq256(8'h28));
            end
        end
    endtask

    task automatic test_stats();
        logic [31:0] exp_pkt;
        logic [31:0] exp_beat;
`ifdef AXIS_WIDTH_CONV_STATS_EN
        exp_pkt  = 32'd10;
        exp_beat = 32'd30;
`else
        exp_pkt  = 32'd0;
        exp_beat = 32'd0;
`endif
        do_reset();
        for (int p = 0; p < 10; p++) begin
            push_in(seq512(p), {64{1'b1}}, 128'(p), 1'b0);
            push_in(seq512(p + 64), 64'h1, 128'(p), 1'b1);
        end
        run_traffic("stats", 30, 200);
        tests_run++;
        if (out_data.size() !== 30) begin tests_failed++; $display("FAIL stats_count got %0d exp 30", out_data.size()); end
        else begin
            tests_run++;
            if (out_keep[2] !== 32'h1 || out_last[2] !== 1'b1 || out_last[1] !== 1'b0 || out_data[2][7:0] !== 8'h40) begin
                tests_failed++; $display("FAIL stats_tail got %h/%b exp 00000001/1", out_keep[2], out_last[2]);
            end
        end
        #1;
        tests_run++;
        if (stat_pkt_cnt !== exp_pkt) begin tests_failed++; $display("FAIL stats_pkt got %0d exp %0d", stat_pkt_cnt, exp_pkt); end
        tests_run++;
        if (stat_beat_cnt !== exp_beat) begin tests_failed++; $display("FAIL stats_beat got %0d exp %0d", stat_beat_cnt, exp_beat); end
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        test_reset();
        test_single_full();
        test_short_tail();
        test_zero_keep();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test sequence");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
